// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low keypad scanner with column drive, debounce and key event pulses.
// Define KEYPAD_REPEAT_EN to add auto-repeat of key_valid while a key stays down.
module keypad_scan #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] RPT_LAST = 16'(REPEAT_DELAY - 1);
  logic [15:0] rpt_cnt;
`endif

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t      state;
  logic [3:0]  row_m, row_s, pat;
  logic [1:0]  col_idx;
  logic [15:0] div, cnt;

  // Rows are asynchronous; idle level is all-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  assign col = ~(4'b0001 << col_idx);

  // Several low rows resolve to the lowest-numbered one.
  function automatic logic [1:0] low_row(input logic [3:0] p);
    if (!p[0])      return 2'd0;
    else if (!p[1]) return 2'd1;
    else if (!p[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      div       <= '0;
      cnt       <= '0;
      pat       <= 4'hF;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (div == DIV_LAST) begin
            div <= '0;
            if (row_s == 4'hF) begin
              col_idx <= col_idx + 2'd1;
            end else begin
              pat   <= row_s;
              cnt   <= '0;
              state <= DEBOUNCE;
            end
          end else begin
            div <= div + 16'd1;
          end
        end
        DEBOUNCE: begin
          if (row_s != pat) begin
            state <= SCAN;
            div   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= PRESSED;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            key_code  <= {low_row(pat), col_idx};
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt   <= '0;
`endif
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        PRESSED: begin
          if (row_s == 4'hF) begin
            state <= RELEASE;
            cnt   <= '0;
          end
`ifdef KEYPAD_REPEAT_EN
          // Repeat phase is frozen during release bounce, resumes if the key comes back.
          else if (rpt_cnt == RPT_LAST) begin
            rpt_cnt   <= '0;
            key_valid <= 1'b1;
          end else begin
            rpt_cnt <= rpt_cnt + 16'd1;
          end
`endif
        end
        RELEASE: begin
          if (row_s != 4'hF) begin
            state <= PRESSED;
          end else if (cnt == DEB_LAST) begin
            state    <= SCAN;
            key_held <= 1'b0;
            col_idx  <= col_idx + 2'd1;
            div      <= '0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt  <= '0;
`endif
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a per-cycle behavioural reference model.
`timescale 1ns/1ps
module tb_keypad_scan;
  localparam int SD = 4, DB = 8, RD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row = 4'hF;
  logic [3:0] col, key_code;
  logic       key_valid, key_held;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 scanning, 1 qualifying a press, 2 key down, 3 qualifying release.
  int         m_mode, m_col, m_t, m_run, m_rpt;
  logic [3:0] m_s1, m_rs, m_pat, m_code;
  logic       m_valid, m_held;

  function automatic int lowest_low(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (!p[i]) return i;
    return 3;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_col = 0; m_t = 0; m_run = 0; m_rpt = 0;
      m_s1 = 4'hF; m_rs = 4'hF; m_pat = 4'hF; m_code = 4'h0;
      m_valid = 1'b0; m_held = 1'b0;
    end else begin
      m_valid = 1'b0;
      case (m_mode)
        0: if (m_t == SD - 1) begin
             m_t = 0;
             if (m_rs == 4'hF) m_col = (m_col + 1) % 4;
             else begin m_pat = m_rs; m_run = 0; m_mode = 1; end
           end else m_t++;
        1: if (m_rs == m_pat) begin
             m_run++;
             if (m_run == DB) begin
               m_mode = 2; m_valid = 1'b1; m_held = 1'b1; m_rpt = 0;
               m_code = 4'(lowest_low(m_pat) * 4 + m_col);
             end
           end else begin m_mode = 0; m_t = 0; end
        2: if (m_rs == 4'hF) begin m_mode = 3; m_run = 0; end
`ifdef KEYPAD_REPEAT_EN
           else begin m_rpt++; if (m_rpt == RD) begin m_rpt = 0; m_valid = 1'b1; end end
`endif
        default: if (m_rs == 4'hF) begin
             m_run++;
             if (m_run == DB) begin
               m_held = 1'b0; m_col = (m_col + 1) % 4; m_t = 0; m_mode = 0; m_rpt = 0;
             end
           end else m_mode = 2;
      endcase
      m_rs = m_s1;
      m_s1 = row;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic [3:0] ec;
      ec = 4'hF;
      ec[m_col] = 1'b0;
      check("model_col", 16'(col), 16'(ec));
      check("model_key_valid", 16'(key_valid), 16'(m_valid));
      check("model_key_held", 16'(key_held), 16'(m_held));
      check("model_key_code", 16'(key_code), 16'(m_code));
    end
  end

  int seen;
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      if (key_valid) seen++;
    end
  endtask

  // Park on the first cycle of the requested column's dwell.
  task automatic wait_dwell(input logic [3:0] c);
    int k;
    k = 0;
    while (col == c && k < 100) begin @(negedge clk); k++; end
    while (col != c && k < 200) begin @(negedge clk); k++; end
    if (col != c) begin
      n_checks++; n_fail++;
      $display("FAIL wait_dwell: col %b never reached %b", col, c);
    end
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!key_valid && k < budget) begin @(negedge clk); k++; end
    check("first_pulse_seen", 16'(key_valid), 16'd1);
  endtask

  logic [3:0] idle_exp [4];
`ifdef KEYPAD_REPEAT_EN
  localparam int CLEAN_PULSES = 2;
  localparam int EXTRA_PULSES = 3;
`else
  localparam int CLEAN_PULSES = 1;
  localparam int EXTRA_PULSES = 0;
`endif

  initial begin
    idle_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    // Reset applied before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_col", 16'(col), 16'h000E);
    check("rst_key_code", 16'(key_code), 16'h0);
    check("rst_key_valid", 16'(key_valid), 16'h0);
    check("rst_key_held", 16'(key_held), 16'h0);
    @(negedge clk) rst = 1'b0;

    // Idle scan: 4 cycles per column.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("idle_col", 16'(col), 16'(idle_exp[k % 4]));
      if (k < 8) repeat (3) @(negedge clk);
    end

    // Clean press on column 1, row 2 -> code 9.
    wait_dwell(4'b1101);
    row = 4'b1011; seen = 0;
    run(40);
    check("clean_pulses", 16'(seen), 16'(CLEAN_PULSES));
    check("clean_code", 16'(key_code), 16'h9);
    check("model_code_pin", 16'(m_code), 16'h9);
    check("clean_held", 16'(key_held), 16'h1);
    row = 4'hF; seen = 0;
    // One cycle to leave PRESSED after row_s goes high, then 8 qualifying cycles.
    run(10);
    check("release_held_still", 16'(key_held), 16'h1);
    run(1);
    check("release_held_fall", 16'(key_held), 16'h0);
    check("release_col_adv", 16'(col), 16'h000B);
    check("release_no_pulse", 16'(seen), 16'h0);

    // Bounce: 3 low cycles at start of column 2 dwell.
    row = 4'b1110; seen = 0;
    run(3);
    row = 4'hF;
    run(5);
    check("bounce_col_frozen", 16'(col), 16'h000B);
    run(5);
    check("bounce_no_pulse", 16'(seen), 16'h0);
    check("bounce_held", 16'(key_held), 16'h0);

    // Multi-row on column 2: rows 0 and 3 low -> code 2.
    wait_dwell(4'b1011);
    row = 4'b0110; seen = 0;
    run(20);
    check("multi_code", 16'(key_code), 16'h2);
    check("multi_pulses", 16'(seen), 16'h1);
    row = 4'hF;
    run(12);
    check("multi_released", 16'(key_held), 16'h0);

    // Long hold on column 0, row 1 -> code 4; repeat pulses only with the feature.
    wait_dwell(4'b1110);
    row = 4'b1101;
    wait_valid(40);
    check("hold_code", 16'(key_code), 16'h4);
    seen = 0;
    run(60);
    check("hold_extra_pulses", 16'(seen), 16'(EXTRA_PULSES));
    row = 4'hF; seen = 0;
    run(12);
    check("hold_release_pulses", 16'(seen), 16'h0);
    check("hold_released", 16'(key_held), 16'h0);

    // Reset mid-debounce aborts the press.
    wait_dwell(4'b1101);
    row = 4'b0111; seen = 0;
    run(6);
    #2 rst = 1'b1;
    #1;
    check("rst_deb_col", 16'(col), 16'h000E);
    check("rst_deb_valid", 16'(key_valid), 16'h0);
    check("rst_deb_code", 16'(key_code), 16'h0);
    row = 4'hF;
    @(negedge clk) rst = 1'b0;
    run(20);
    check("rst_deb_no_pulse", 16'(seen), 16'h0);

    // Reset while held: column 0, row 2 -> code 8, then cleared.
    wait_dwell(4'b1110);
    row = 4'b1011;
    run(20);
    check("held_code", 16'(key_code), 16'h8);
    check("held_high", 16'(key_held), 16'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_held_held", 16'(key_held), 16'h0);
    check("rst_held_code", 16'(key_code), 16'h0);
    check("rst_held_col", 16'(col), 16'h000E);
    row = 4'hF;
    @(negedge clk) rst = 1'b0;
    seen = 0;
    run(16);
    check("rst_held_no_pulse", 16'(seen), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
